sdram_delay_master: RTL
=======================

SDRAM_DELAY_MASTER -- requirements
Module: sdram_delay_master

Interface
REQ-001 Parameter: BASE_ADDR, 25'h0000000, word base address of the ring buffer in SDRAM.
REQ-002 Parameter: DEPTH_LOG2, 16, ring buffer depth is 2^DEPTH_LOG2 16-bit words (legal range 4..24).
REQ-003 Port: clk_clk  in  1  sole clock; all logic rising-edge.
REQ-004 Port: reset_reset  in  1  synchronous, active-high reset.
REQ-005 Port: sample_in / sample_in_valid  in  16 / 1  audio sample and its one-cycle strobe.
REQ-006 Port: delay_len  in  24  delay in samples, sampled on each accepted sample_in_valid.
REQ-007 Port: sample_out / sample_out_valid  out  16 / 1  delayed sample and its one-cycle strobe.
REQ-008 Port: overrun  out  1  sticky flag, sample_in_valid arrived while busy.
REQ-009 Port: avm_address  out  25; avm_byteenable_n  out  2; avm_chipselect  out  1; avm_writedata  out  16; avm_read_n  out  1; avm_write_n  out  1. These are Avalon-MM master outputs to the SDRAM controller slave.
REQ-010 Port: avm_readdata  in  16; avm_readdatavalid  in  1; avm_waitrequest  in  1.

Function
REQ-011 FSM states IDLE, WRITE, READ, WAIT_DATA, EMIT; exactly one active.
REQ-012 IDLE + sample_in_valid: latch sample_in and min(delay_len, 2^DEPTH_LOG2-1) (clamp), go WRITE next cycle.
REQ-013 WRITE: chipselect=1, write_n=0, byteenable_n=2'b00, address=BASE_ADDR+wr_ptr, writedata=latched sample; all held stable while waitrequest=1.
REQ-014 WRITE with waitrequest=0: write accepted; if latched delay=0 go EMIT with the latched sample, else go READ.
REQ-015 READ: chipselect=1, read_n=0, address=BASE_ADDR+((wr_ptr-delay) mod 2^DEPTH_LOG2); held while waitrequest=1; on waitrequest=0 go WAIT_DATA.
REQ-016 Outside WRITE/READ: chipselect=0, read_n=1, write_n=1; never read_n=0 and write_n=0 together.
REQ-017 WAIT_DATA: capture avm_readdata on the avm_readdatavalid cycle, go EMIT.
REQ-018 EMIT: sample_out_valid=1 for exactly one cycle with the captured/bypass data; wr_ptr increments (wraps 2^DEPTH_LOG2-1 -> 0); fill_cnt increments, saturating at 2^DEPTH_LOG2; return IDLE.
REQ-019 sample_out holds its value between strobes.
REQ-020 Zero-wait latency: sample_in_valid at cycle 0 -> write at cycle 1, read at cycle 2, sample_out_valid one cycle after readdatavalid.
REQ-021 sample_in_valid in any state other than IDLE: sample dropped, overrun set to 1, pointers unchanged; overrun clears only on reset.
REQ-022 Address arithmetic is 25-bit modulo 2^25; ring offset is DEPTH_LOG2-bit modulo.
REQ-023 avm_readdatavalid outside WAIT_DATA is ignored.

Reset
REQ-024 reset_reset=1 at a clock edge: state=IDLE, wr_ptr=0, fill_cnt=0, overrun=0, sample_out=0, sample_out_valid=0, chipselect=0, read_n=1, write_n=1, address=0, writedata=0, byteenable_n=2'b11.
REQ-025 Reset mid-transaction abandons the command immediately, with no completion and no output strobe.

Configuration
REQ-026 Macro SDRAM_DELAY_FILL_MUTE_EN defined: when fill_cnt < latched delay, READ/WAIT_DATA are skipped, WRITE goes directly to EMIT, and sample_out=0.
REQ-027 Macro not defined: the read is always performed and the SDRAM contents are emitted regardless of fill level.

Verification
REQ-028 Reset, then delay_len=3 and samples 1,2,3,4,5 with waitrequest=0 and model latency 2: with macro, outputs are 0,0,0,1,2; without macro, outputs are memory contents,...,1,2.
REQ-029 delay_len=0, sample 16'h1234 -> exactly one write at BASE_ADDR, no read, sample_out=16'h1234 two cycles after the strobe.
REQ-030 waitrequest held high 5 cycles during WRITE, then READ -> address, writedata and control remain stable throughout, and each command is issued once.
REQ-031 DEPTH_LOG2=4, BASE_ADDR=25'h100, 20 samples, delay 2 -> write addresses wrap 0x10F -> 0x100, and read address = write address minus 2 modulo 16.
REQ-032 Second sample_in_valid one cycle after the first -> overrun=1, only one write issued, and the first sample completes normally.
REQ-033 reset_reset asserted during WAIT_DATA, with readdatavalid arriving afterwards -> no sample_out_valid, all outputs at reset values, and the next sample writes at BASE_ADDR.

Source files
------------

// File: rtl/sdram_delay_master_if.sv
// Avalon-MM bus between the delay master and the SDRAM controller slave.
// Active-low byteenable/read/write strobes follow the controller's native polarity.
interface sdram_delay_master_if;
  logic [24:0] avm_address;
  logic [1:0]  avm_byteenable_n;
  logic        avm_chipselect;
  logic [15:0] avm_writedata;
  logic        avm_read_n;
  logic        avm_write_n;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_byteenable_n, avm_chipselect, avm_writedata,
           avm_read_n, avm_write_n,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_byteenable_n, avm_chipselect, avm_writedata,
           avm_read_n, avm_write_n,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/sdram_delay_master.sv
// Audio delay line: each sample is written to an SDRAM ring buffer and the sample
// 'delay' positions back is read and emitted. Define SDRAM_DELAY_FILL_MUTE_EN to mute unfilled history.
module sdram_delay_master #(
  parameter logic [24:0] BASE_ADDR  = 25'h0000000,
  parameter int          DEPTH_LOG2 = 16
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic [15:0]           sample_in,
  input  logic                  sample_in_valid,
  input  logic [23:0]           delay_len,
  output logic [15:0]           sample_out,
  output logic                  sample_out_valid,
  output logic                  overrun,
  sdram_delay_master_if.master  avm,
  output logic [2:0]            state_dbg,
  output logic [DEPTH_LOG2:0]   fill_dbg
);

  // Bus handshake: a command (chipselect=1) is held stable and completes on the
  // first cycle with avm_waitrequest=0; read data is taken only when
  // avm_readdatavalid=1 in WAIT_DATA. sample_in_valid/sample_out_valid are
  // single-cycle strobes with no back-pressure.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ      = 3'd2,
    WAIT_DATA = 3'd3,
    EMIT      = 3'd4
  } state_t;

  localparam logic [23:0]         DELAY_MAX = 24'((64'd1 << DEPTH_LOG2) - 64'd1);
  localparam logic [DEPTH_LOG2:0] FILL_MAX  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] FILL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  state_t state, state_nx;

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] delay_q;
  logic [DEPTH_LOG2-1:0] delay_clamped;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   fill_cnt;
  logic [15:0]           sample_q;
  logic                  load_out;
  logic [15:0]           out_nx;
  logic                  mute;

  assign delay_clamped = (delay_len > DELAY_MAX) ? DELAY_MAX[DEPTH_LOG2-1:0]
                                                 : delay_len[DEPTH_LOG2-1:0];
  // Ring offset wraps naturally at DEPTH_LOG2 bits.
  assign rd_ptr = wr_ptr - delay_q;

`ifdef SDRAM_DELAY_FILL_MUTE_EN
  assign mute = (fill_cnt < {1'b0, delay_q});
`else
  assign mute = 1'b0;
`endif

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_out = 1'b0;
    out_nx   = sample_q;
    case (state)
      IDLE: if (sample_in_valid) state_nx = WRITE;
      WRITE: begin
        if (!avm.avm_waitrequest) begin
          if (delay_q == '0) begin
            state_nx = EMIT;
            load_out = 1'b1;
          end else if (mute) begin
            state_nx = EMIT;
            load_out = 1'b1;
            out_nx   = '0;
          end else begin
            state_nx = READ;
          end
        end
      end
      READ: if (!avm.avm_waitrequest) state_nx = WAIT_DATA;
      WAIT_DATA: begin
        if (avm.avm_readdatavalid) begin
          state_nx = EMIT;
          load_out = 1'b1;
          out_nx   = avm.avm_readdata;
        end
      end
      EMIT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs decode straight from the state register, so they stay
  // constant for as long as waitrequest holds the FSM in WRITE or READ.
  always_comb begin
    avm.avm_address      = '0;
    avm.avm_writedata    = '0;
    avm.avm_byteenable_n = 2'b11;
    avm.avm_chipselect   = 1'b0;
    avm.avm_read_n       = 1'b1;
    avm.avm_write_n      = 1'b1;
    case (state)
      WRITE: begin
        avm.avm_address      = BASE_ADDR + 25'(wr_ptr);
        avm.avm_writedata    = sample_q;
        avm.avm_byteenable_n = 2'b00;
        avm.avm_chipselect   = 1'b1;
        avm.avm_write_n      = 1'b0;
      end
      READ: begin
        avm.avm_address      = BASE_ADDR + 25'(rd_ptr);
        avm.avm_byteenable_n = 2'b00;
        avm.avm_chipselect   = 1'b1;
        avm.avm_read_n       = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      delay_q    <= '0;
      sample_q   <= '0;
      sample_out <= '0;
      overrun    <= 1'b0;
    end else begin
      if (state == IDLE && sample_in_valid) begin
        sample_q <= sample_in;
        delay_q  <= delay_clamped;
      end
      if (state != IDLE && sample_in_valid) overrun <= 1'b1;
      if (load_out) sample_out <= out_nx;
      if (state == EMIT) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + FILL_ONE;
      end
    end
  end

  assign sample_out_valid = (state == EMIT);
  assign state_dbg        = state;
  assign fill_dbg         = fill_cnt;

endmodule
